// File: rtl/cpu_multiply_pkg.sv
// Shared types and constants for the cpu_multiply execute-stage multiplier.
// Holds the FSM state enum, the half-width split and the request latency.
package cpu_multiply_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int HALF = MUL_WIDTH / 2;

`ifdef CPU_MULTIPLY_FAST_EN
  localparam int MUL_LATENCY = 1;
`else
  localparam int MUL_LATENCY = 4;
`endif

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    PARTIAL,
    SUM,
    DONE
  } mul_state_e;

endpackage

// File: rtl/cpu_multiply_partial.sv
// Unsigned HW x HW combinational multiplier used for one partial product.
// Ports: a_i, b_i operands (HW bits); p_o product (2*HW bits).
module cpu_multiply_partial
  import cpu_multiply_pkg::*;
#(
  parameter int HW = HALF
) (
  input  logic [HW-1:0]   a_i,
  input  logic [HW-1:0]   b_i,
  output logic [2*HW-1:0] p_o
);

  assign p_o = {{HW{1'b0}}, a_i} * {{HW{1'b0}}, b_i};

endmodule

// File: rtl/cpu_multiply.sv
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH multiplier (MUL/MULH/MULHU), level-held
// request i_latch, result o_result valid while o_ready. Async active-high i_reset.
// Macro CPU_MULTIPLY_FAST_EN: single-cycle combinational product, IDLE/DONE only.
// Ports: i_clock, i_reset, i_latch, i_signed, i_op1, i_op2 -> o_ready, o_result.
module cpu_multiply
  import cpu_multiply_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_latch,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_op1,
  input  logic [WIDTH-1:0]   i_op2,
  output logic               o_ready,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int HW = WIDTH / 2;

  // Unsigned magnitude; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] v,
    input logic             s
  );
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  mul_state_e           state_q, state_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

`ifdef CPU_MULTIPLY_FAST_EN

  logic [WIDTH-1:0]   m1, m2;
  logic [2*WIDTH-1:0] pmag, prod;

  assign m1   = mag(i_op1, i_signed);
  assign m2   = mag(i_op2, i_signed);
  assign pmag = {{WIDTH{1'b0}}, m1} * {{WIDTH{1'b0}}, m2};
  assign prod = (i_signed && (i_op1[WIDTH-1] ^ i_op2[WIDTH-1])) ? -pmag : pmag;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        if (i_latch) begin
          result_d = prod;
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!i_latch) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`else

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sgn_q, sgn_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   ll_q, ll_d;
  logic [WIDTH-1:0]   lh_q, lh_d;
  logic [WIDTH-1:0]   hl_q, hl_d;
  logic [WIDTH-1:0]   hh_q, hh_d;
  logic [2*WIDTH-1:0] sum_q, sum_d;

  logic [WIDTH-1:0]   ma, mb;
  logic [WIDTH-1:0]   ll_w, lh_w, hl_w, hh_w;

  assign ma = mag(a_q, sgn_q);
  assign mb = mag(b_q, sgn_q);

  cpu_multiply_partial #(.HW(HW)) u_ll (
    .a_i(ma[HW-1:0]),     .b_i(mb[HW-1:0]),     .p_o(ll_w)
  );
  cpu_multiply_partial #(.HW(HW)) u_lh (
    .a_i(ma[HW-1:0]),     .b_i(mb[WIDTH-1:HW]), .p_o(lh_w)
  );
  cpu_multiply_partial #(.HW(HW)) u_hl (
    .a_i(ma[WIDTH-1:HW]), .b_i(mb[HW-1:0]),     .p_o(hl_w)
  );
  cpu_multiply_partial #(.HW(HW)) u_hh (
    .a_i(ma[WIDTH-1:HW]), .b_i(mb[WIDTH-1:HW]), .p_o(hh_w)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      ll_q     <= '0;
      lh_q     <= '0;
      hl_q     <= '0;
      hh_q     <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      ll_q     <= ll_d;
      lh_q     <= lh_d;
      hl_q     <= hl_d;
      hh_q     <= hh_d;
      sum_q    <= sum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    ll_d     = ll_q;
    lh_d     = lh_q;
    hl_d     = hl_q;
    hh_d     = hh_q;
    sum_d    = sum_q;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        if (i_latch) begin
          a_d     = i_op1;
          b_d     = i_op2;
          sgn_d   = i_signed;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!i_latch) state_d = IDLE;
        else begin
          neg_d   = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          ll_d    = ll_w;
          lh_d    = lh_w;
          hl_d    = hl_w;
          hh_d    = hh_w;
          state_d = PARTIAL;
        end
      end
      PARTIAL: begin
        if (!i_latch) state_d = IDLE;
        else begin
          // Cross terms summed at full width so their carry is kept.
          sum_d   = {{WIDTH{1'b0}}, ll_q}
                  + ({{WIDTH{1'b0}}, lh_q} << HW)
                  + ({{WIDTH{1'b0}}, hl_q} << HW)
                  + {hh_q, {WIDTH{1'b0}}};
          state_d = SUM;
        end
      end
      SUM: begin
        if (!i_latch) state_d = IDLE;
        else begin
          result_d = neg_q ? -sum_q : sum_q;
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!i_latch) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`endif

  assign o_ready  = ready_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_cpu_multiply.sv
// Directed bench for cpu_multiply: handshake, latency, signed/unsigned,
// extremes, abort and asynchronous reset.
module tb_cpu_multiply;
  import cpu_multiply_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        latch = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        ready;
  logic [63:0] result;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  cpu_multiply #(.WIDTH(32)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_latch (latch),
    .i_signed(sgn),
    .i_op1   (op1),
    .i_op2   (op2),
    .o_ready (ready),
    .o_result(result)
  );

  task automatic run_req(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp,
                         input string nm);
    @(negedge clk);
    op1 = a; op2 = b; sgn = s; latch = 1'b1;
    for (int i = 1; i <= MUL_LATENCY; i++) begin
      @(negedge clk);
      if (i < MUL_LATENCY) begin
        // Operand churn after capture must not affect the product.
        op1 = ~a; op2 = b ^ 32'h5A5A_1234; sgn = ~s;
        vecs++;
        if (ready !== 1'b0) begin
          errs++;
          $display("FAIL %s early_ready edge %0d: got %b want 0", nm, i, ready);
        end
      end else begin
        vecs++;
        if (ready !== 1'b1 || result !== exp) begin
          errs++;
          $display("FAIL %s done: ready %b result %h want 1 %h",
                   nm, ready, result, exp);
        end
      end
    end
    op1 = 32'h1357_9BDF; op2 = 32'h2468_ACE0;
    @(negedge clk);
    vecs++;
    if (ready !== 1'b1 || result !== exp) begin
      errs++;
      $display("FAIL %s hold: ready %b result %h want 1 %h",
               nm, ready, result, exp);
    end
    latch = 1'b0;
    @(negedge clk);
    vecs++;
    if (ready !== 1'b0 || result !== exp) begin
      errs++;
      $display("FAIL %s drop: ready %b result %h want 0 %h",
               nm, ready, result, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    vecs++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errs++;
      $display("FAIL reset_init: ready %b result %h want 0 0", ready, result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    run_req(32'd111, 32'd222, 1'b0, 64'd24642, "u_basic");
    run_req(32'd555, 32'd666, 1'b0, 64'd369630, "u_second");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vecs++;
      if (ready !== 1'b0 || result !== 64'd369630) begin
        errs++;
        $display("FAIL idle_%0d: ready %b result %h want 0 %h",
                 i, ready, result, 64'd369630);
      end
    end
  endtask

  task automatic test_signed;
    run_req(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "s_neg3x7");
    run_req(32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB, "u_fffdx7");
  endtask

  task automatic test_extremes;
    run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
            64'hFFFF_FFFE_0000_0001, "u_max");
    run_req(32'h8000_0000, 32'h8000_0000, 1'b1,
            64'h4000_0000_0000_0000, "s_min");
    run_req(32'h8000_0000, 32'd3, 1'b1,
            64'hFFFF_FFFE_8000_0000, "s_minx3");
  endtask

  task automatic test_abort;
    logic [63:0] prev;
    prev = result;
    @(negedge clk);
    op1 = 32'd9; op2 = 32'd9; sgn = 1'b0; latch = 1'b1;
    @(negedge clk);
    @(negedge clk);
    latch = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vecs++;
      if (ready !== 1'b0 || result !== prev) begin
        errs++;
        $display("FAIL abort_%0d: ready %b result %h want 0 %h",
                 i, ready, result, prev);
      end
    end
    run_req(32'd12, 32'd12, 1'b0, 64'd144, "after_abort");
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    op1 = 32'd77; op2 = 32'd88; sgn = 1'b0; latch = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errs++;
      $display("FAIL rst_mid: ready %b result %h want 0 0", ready, result);
    end
    latch = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_req(32'd1000, 32'd3000, 1'b0, 64'd3000000, "after_rst_mid");
    @(negedge clk);
    op1 = 32'd5; op2 = 32'hFFFF_FFFF; sgn = 1'b1; latch = 1'b1;
    for (int i = 0; i < MUL_LATENCY; i++) @(posedge clk);
    #2;
    vecs++;
    if (ready !== 1'b1 || result !== 64'hFFFF_FFFF_FFFF_FFFB) begin
      errs++;
      $display("FAIL pre_rst_done: ready %b result %h want 1 %h",
               ready, result, 64'hFFFF_FFFF_FFFF_FFFB);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errs++;
      $display("FAIL rst_done: ready %b result %h want 0 0", ready, result);
    end
    latch = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_req(32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b1, 64'd100, "after_rst_done");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_extremes();
    test_abort();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
